// File: rtl/score_decision_engine_if.sv
// Frame-in / gesture-out handshake bundle for score_decision_engine.
interface score_decision_engine_if #(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned ACC_BITS    = 24,
    parameter int unsigned CONF_BITS   = 4
);
    localparam int unsigned IDX_BITS = $clog2(NUM_CLASSES);

    logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat;
    logic                            scores_valid;
    logic                            scores_ready;
    logic [IDX_BITS-1:0]             gesture;
    logic                            gesture_valid;
    logic                            gesture_ready;
    logic [CONF_BITS-1:0]            gesture_confidence;

    modport master (
        output scores_flat, scores_valid, gesture_ready,
        input  scores_ready, gesture, gesture_valid, gesture_confidence
    );

    modport slave (
        input  scores_flat, scores_valid, gesture_ready,
        output scores_ready, gesture, gesture_valid, gesture_confidence
    );
endinterface

// File: rtl/score_decision_engine.sv
// Argmax over per-frame class scores with threshold and persistence filtering.
// Optional: define SCORE_DECISION_MARGIN_EN to also require a best-minus-second margin.
module score_decision_engine #(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned ACC_BITS    = 24,
    parameter int          MIN_SCORE   = 30,
    parameter int          MIN_MARGIN  = 16,
    parameter int unsigned PERSISTENCE = 2,
    parameter int unsigned CONF_BITS   = 4,
    parameter int unsigned CONF_SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    score_decision_engine_if.slave   bus,
    output logic [7:0]               drop_count,
    output logic [1:0]               debug_state
);
    localparam int unsigned IDX_BITS = $clog2(NUM_CLASSES);
    localparam int unsigned EXT_BITS = ACC_BITS + 1;
    localparam int unsigned CONF_MAX = (1 << CONF_BITS) - 1;
    localparam int unsigned LAST_IDX = NUM_CLASSES - 1;
    localparam logic signed [ACC_BITS-1:0] SCORE_NEG   = {1'b1, {(ACC_BITS-1){1'b0}}};
    localparam logic signed [EXT_BITS-1:0] MIN_SCORE_X = EXT_BITS'(MIN_SCORE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t                     state, state_nxt;
    logic signed [ACC_BITS-1:0] scores_q [NUM_CLASSES];
    logic signed [ACC_BITS-1:0] scores_nxt [NUM_CLASSES];
    logic [IDX_BITS-1:0]        idx, idx_nxt;
    logic [IDX_BITS-1:0]        best_idx, best_idx_nxt;
    logic [IDX_BITS-1:0]        cand, cand_nxt, cand_upd;
    logic [IDX_BITS-1:0]        gesture_q, gesture_nxt;
    logic signed [ACC_BITS-1:0] best, best_nxt, cur;
    logic [3:0]                 streak, streak_nxt, streak_upd;
    logic                       dec_stage, dec_stage_nxt;
    logic                       pass_q, pass_nxt, pass_c;
    logic [CONF_BITS-1:0]       conf_q, conf_nxt, conf_c;
    logic [CONF_BITS-1:0]       gconf_q, gconf_nxt;
    logic                       gvalid_q, gvalid_nxt;
    logic                       ready_q;
    logic [7:0]                 drop_q, drop_nxt;
    logic signed [EXT_BITS-1:0] best_x, above;
    logic [EXT_BITS-1:0]        conf_raw;
`ifdef SCORE_DECISION_MARGIN_EN
    localparam logic signed [EXT_BITS-1:0] MIN_MARGIN_X = EXT_BITS'(MIN_MARGIN);
    logic signed [ACC_BITS-1:0] second, second_nxt;
    logic signed [EXT_BITS-1:0] margin;
`endif

    assign bus.scores_ready       = ready_q;
    assign bus.gesture            = gesture_q;
    assign bus.gesture_valid      = gvalid_q;
    assign bus.gesture_confidence = gconf_q;
    assign drop_count             = drop_q;
    assign debug_state            = state;

    // Acceptance test and confidence, evaluated at ACC_BITS+1 so differences cannot wrap
    always_comb begin
        best_x   = {best[ACC_BITS-1], best};
        above    = best_x - MIN_SCORE_X;
        conf_raw = above >> CONF_SHIFT;
        conf_c   = (conf_raw > EXT_BITS'(CONF_MAX)) ? CONF_BITS'(CONF_MAX) : CONF_BITS'(conf_raw);
`ifdef SCORE_DECISION_MARGIN_EN
        margin   = best_x - {second[ACC_BITS-1], second};
        pass_c   = (best_x >= MIN_SCORE_X) && (margin >= MIN_MARGIN_X);
`else
        pass_c   = (best_x >= MIN_SCORE_X);
`endif
    end

    always_comb begin
        state_nxt     = state;
        scores_nxt    = scores_q;
        idx_nxt       = idx;
        best_nxt      = best;
        best_idx_nxt  = best_idx;
        cand_nxt      = cand;
        cand_upd      = cand;
        streak_nxt    = streak;
        streak_upd    = streak;
        dec_stage_nxt = dec_stage;
        pass_nxt      = pass_q;
        conf_nxt      = conf_q;
        gesture_nxt   = gesture_q;
        gconf_nxt     = gconf_q;
        gvalid_nxt    = gvalid_q;
        drop_nxt      = drop_q;
        cur           = scores_q[idx];
`ifdef SCORE_DECISION_MARGIN_EN
        second_nxt    = second;
`endif

        if (bus.scores_valid && !ready_q && (drop_q != 8'hFF)) begin
            drop_nxt = drop_q + 8'd1;
        end

        case (state)
            IDLE: begin
                if (bus.scores_valid && ready_q) begin
                    for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                        scores_nxt[k] = bus.scores_flat[k*ACC_BITS +: ACC_BITS];
                    end
                    idx_nxt   = '0;
                    best_nxt  = SCORE_NEG;
`ifdef SCORE_DECISION_MARGIN_EN
                    second_nxt = SCORE_NEG;
`endif
                    state_nxt = SCAN;
                end
            end
            // Strict compares keep the lower index on ties
            SCAN: begin
                if (cur > best) begin
`ifdef SCORE_DECISION_MARGIN_EN
                    second_nxt   = best;
`endif
                    best_nxt     = cur;
                    best_idx_nxt = idx;
`ifdef SCORE_DECISION_MARGIN_EN
                end else if (cur > second) begin
                    second_nxt = cur;
`endif
                end
                if (idx == IDX_BITS'(LAST_IDX)) begin
                    dec_stage_nxt = 1'b0;
                    state_nxt     = DECIDE;
                end else begin
                    idx_nxt = idx + IDX_BITS'(1);
                end
            end
            // First cycle registers the acceptance result, second applies it
            DECIDE: begin
                if (!dec_stage) begin
                    pass_nxt      = pass_c;
                    conf_nxt      = conf_c;
                    dec_stage_nxt = 1'b1;
                end else begin
                    dec_stage_nxt = 1'b0;
                    if (pass_q) begin
                        if (best_idx == cand) begin
                            streak_upd = (streak == 4'd15) ? 4'd15 : streak + 4'd1;
                        end else begin
                            cand_upd   = best_idx;
                            streak_upd = 4'd1;
                        end
                    end else begin
                        streak_upd = 4'd0;
                    end
                    cand_nxt   = cand_upd;
                    streak_nxt = streak_upd;
                    if (32'(streak_upd) >= PERSISTENCE) begin
                        gesture_nxt = cand_upd;
                        gconf_nxt   = conf_q;
                        gvalid_nxt  = 1'b1;
                        state_nxt   = EMIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            EMIT: begin
                if (bus.gesture_ready) begin
                    gvalid_nxt = 1'b0;
                    streak_nxt = 4'd0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int k = 0; k < int'(NUM_CLASSES); k++) scores_q[k] <= '0;
            idx       <= '0;
            best      <= '0;
            best_idx  <= '0;
            cand      <= '0;
            streak    <= 4'd0;
            dec_stage <= 1'b0;
            pass_q    <= 1'b0;
            conf_q    <= '0;
            gesture_q <= '0;
            gconf_q   <= '0;
            gvalid_q  <= 1'b0;
            ready_q   <= 1'b1;
            drop_q    <= 8'd0;
`ifdef SCORE_DECISION_MARGIN_EN
            second    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            scores_q  <= scores_nxt;
            idx       <= idx_nxt;
            best      <= best_nxt;
            best_idx  <= best_idx_nxt;
            cand      <= cand_nxt;
            streak    <= streak_nxt;
            dec_stage <= dec_stage_nxt;
            pass_q    <= pass_nxt;
            conf_q    <= conf_nxt;
            gesture_q <= gesture_nxt;
            gconf_q   <= gconf_nxt;
            gvalid_q  <= gvalid_nxt;
            ready_q   <= (state_nxt == IDLE);
            drop_q    <= drop_nxt;
`ifdef SCORE_DECISION_MARGIN_EN
            second    <= second_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_score_decision_engine.sv
// Directed bench for score_decision_engine against a frame-level reference model.
module tb_score_decision_engine;
    localparam int unsigned NC   = 4;
    localparam int unsigned AB   = 24;
    localparam int unsigned CB   = 4;
    localparam int          MINS = 30;
    localparam int          MARG = 16;
    localparam int          PERS = 2;
    localparam int          SHFT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] drop_count;
    logic [1:0] debug_state;

    score_decision_engine_if #(.NUM_CLASSES(NC), .ACC_BITS(AB), .CONF_BITS(CB)) bus ();

    score_decision_engine #(
        .NUM_CLASSES(NC), .ACC_BITS(AB), .MIN_SCORE(MINS), .MIN_MARGIN(MARG),
        .PERSISTENCE(PERS), .CONF_BITS(CB), .CONF_SHIFT(SHFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .drop_count(drop_count), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level decision, timed by the required accept-to-result latency
    int m_ready, m_valid, m_gest, m_conf, m_drop, m_streak, m_cand, m_busy;
    int p_best, p_second, p_idx;

    task automatic eval_frame(input logic [NC*AB-1:0] fl);
        int s;
        p_best = -(1 << (AB - 1));
        p_second = p_best;
        p_idx = 0;
        for (int k = 0; k < int'(NC); k++) begin
            s = $signed(fl[k*AB +: AB]);
            if (s > p_best) begin
                p_second = p_best; p_best = s; p_idx = k;
            end else if (s > p_second) begin
                p_second = s;
            end
        end
    endtask

    task automatic decide();
        bit pass;
        int c;
        pass = (p_best >= MINS);
`ifdef SCORE_DECISION_MARGIN_EN
        pass = pass && ((p_best - p_second) >= MARG);
`endif
        if (!pass) m_streak = 0;
        else if (p_idx == m_cand) m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
        else begin m_cand = p_idx; m_streak = 1; end
        if (m_streak >= PERS) begin
            c = (p_best - MINS) >>> SHFT;
            if (c > 15) c = 15;
            m_valid = 1; m_gest = m_cand; m_conf = c;
        end else begin
            m_ready = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1; m_valid = 0; m_gest = 0; m_conf = 0; m_drop = 0;
            m_streak = 0; m_cand = 0; m_busy = 0;
        end else begin
            if (bus.scores_valid && m_ready == 0 && m_drop < 255) m_drop++;
            if (m_ready == 1 && bus.scores_valid) begin
                eval_frame(bus.scores_flat);
                m_ready = 0;
                m_busy = int'(NC) + 2;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) decide();
            end else if (m_valid == 1 && bus.gesture_ready) begin
                m_valid = 0; m_streak = 0; m_ready = 1;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("scores_ready", int'(bus.scores_ready), m_ready);
            check("gesture_valid", int'(bus.gesture_valid), m_valid);
            check("gesture", int'(bus.gesture), m_gest);
            check("gesture_confidence", int'(bus.gesture_confidence), m_conf);
            check("drop_count", int'(drop_count), m_drop);
            if (m_ready == 1) check("debug_state_idle", int'(debug_state), 0);
            else if (m_valid == 1) check("debug_state_emit", int'(debug_state), 3);
        end
    end

    int emit_cnt = 0, last_gest = -1, last_conf = -1;
    always @(posedge clk) begin
        if (rst_n && bus.gesture_valid && bus.gesture_ready) begin
            emit_cnt++;
            last_gest = int'(bus.gesture);
            last_conf = int'(bus.gesture_confidence);
        end
    end

    function automatic logic [NC*AB-1:0] pack(input int a, input int b, input int c, input int d);
        return {AB'(d), AB'(c), AB'(b), AB'(a)};
    endfunction

    task automatic send(input int a, input int b, input int c, input int d);
        int n = 0;
        @(negedge clk);
        while (!bus.scores_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.scores_ready) check("send_ready_timeout", 0, 1);
        bus.scores_flat  = pack(a, b, c, d);
        bus.scores_valid = 1'b1;
        @(posedge clk); #1;
        bus.scores_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.scores_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!bus.scores_ready) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1; lat++;
            if (bus.gesture_valid) break;
        end
        if (!bus.gesture_valid) check("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        int lat, base;
        rst_n = 1'b0;
        bus.scores_valid = 1'b0;
        bus.scores_flat = '0;
        bus.gesture_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; chk_en = 1;
        @(posedge clk); #1;
        check("reset_ready", int'(bus.scores_ready), 1);
        check("reset_valid", int'(bus.gesture_valid), 0);
        check("reset_drop", int'(drop_count), 0);
        check("reset_state", int'(debug_state), 0);

        // Same winner twice: one emission, class 1, confidence (100-30)>>4
        send(10, 100, 20, 5); wait_ready();
        check("t1_no_emit_first", emit_cnt, 0);
        send(10, 100, 20, 5); wait_valid(lat);
        check("t1_latency", lat, 6);
        check("t1_gesture", int'(bus.gesture), 1);
        check("t1_conf", int'(bus.gesture_confidence), 4);
        wait_ready();
        check("t1_emit_cnt", emit_cnt, 1);

        // Tie between classes 0 and 1
        send(50, 50, 0, 0); wait_ready();
        send(50, 50, 0, 0); wait_ready();
`ifdef SCORE_DECISION_MARGIN_EN
        check("t2_emit_cnt", emit_cnt, 1);
`else
        check("t2_emit_cnt", emit_cnt, 2);
        check("t2_gesture", last_gest, 0);
        check("t2_conf", last_conf, 1);
`endif
        base = emit_cnt;

        // Below threshold, then alternating winners
        repeat (3) begin send(-100, 29, 0, -5); wait_ready(); end
        repeat (2) begin
            send(100, 0, 0, 0); wait_ready();
            send(0, 100, 0, 0); wait_ready();
        end
        check("t3_no_emit", emit_cnt, base);

        // Stalled emission with frames offered while busy
        bus.gesture_ready = 1'b0;
        send(10, 100, 20, 5); wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.scores_flat  = pack(1, 2, 3, 4);
            bus.scores_valid = (i == 1 || i == 4 || i == 7);
        end
        @(negedge clk); bus.scores_valid = 1'b0;
        #1;
        check("t4_drop", int'(drop_count), 3);
        check("t4_ready_low", int'(bus.scores_ready), 0);
        check("t4_valid_held", int'(bus.gesture_valid), 1);
        check("t4_gesture_held", int'(bus.gesture), 1);
        check("t4_conf_held", int'(bus.gesture_confidence), 4);
        bus.gesture_ready = 1'b1;
        wait_ready();
        check("t4_emit_cnt", emit_cnt, base + 1);

        // Asynchronous reset in the middle of a scan
        send(200, 0, 0, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t5_gesture", int'(bus.gesture), 0);
        check("t5_valid", int'(bus.gesture_valid), 0);
        check("t5_conf", int'(bus.gesture_confidence), 0);
        check("t5_drop", int'(drop_count), 0);
        check("t5_state", int'(debug_state), 0);
        check("t5_ready", int'(bus.scores_ready), 1);
        @(negedge clk); rst_n = 1'b1;

        // Large score saturates the confidence
        send(2000, -8388608, 0, 0); wait_ready();
        send(2000, -8388608, 0, 0); wait_ready();
        check("t6_emit_cnt", emit_cnt, base + 2);
        check("t6_gesture", last_gest, 0);
        check("t6_conf", last_conf, 15);

        repeat (3) @(posedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
